// File: rtl/up_dn_sense_ctrl.sv
//------------------------------------------------------------------------------
// up_dn_sense_ctrl: steers an up/down counter between lo_limit and hi_limit.
// Optional macro UP_DN_CTRL_TURN_CNT_EN builds the turn_cnt reversal counter.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module up_dn_sense_ctrl #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] lo_limit,
  input  logic [WIDTH-1:0] hi_limit,
  input  logic [WIDTH-1:0] cnt_in,
  output logic             sense,
  output logic             turn,
  output logic             fault,
  output logic             cfg_err,
  output logic [CNT_W-1:0] turn_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UP    = 2'd1,
    ST_DOWN  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_sense;
  logic             r_turn;
  logic             r_fault;

  logic [WIDTH:0]   w_lo_p1;
  logic [WIDTH:0]   w_lo_p2;
  logic             w_above;
  logic             w_below;
  logic             w_out;
  logic             w_at_top;
  logic             w_at_bot;
  logic             w_run;
  logic             w_rev;

  // Limit arithmetic is one bit wider so lo_limit near full scale cannot wrap.
  assign w_lo_p1  = {1'b0, lo_limit} + (WIDTH+1)'(1);
  assign w_lo_p2  = {1'b0, lo_limit} + (WIDTH+1)'(2);
  assign cfg_err  = ({1'b0, hi_limit} < w_lo_p2);

  assign w_above  = (cnt_in > hi_limit);
  assign w_below  = (cnt_in < lo_limit);
  assign w_out    = w_above | w_below;
  assign w_at_top = (cnt_in >= (hi_limit - WIDTH'(1)));
  assign w_at_bot = ({1'b0, cnt_in} <= w_lo_p1);
  assign w_run    = enable & ~cfg_err;

  assign w_rev = w_run & ~w_out &
                 (((r_state == ST_UP) & w_at_top) | ((r_state == ST_DOWN) & w_at_bot));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sense <= 1'b1;
      r_turn  <= 1'b0;
      r_fault <= 1'b0;
    end else begin
      r_turn <= 1'b0;
      if (!w_run) begin
        r_state <= ST_IDLE;
        r_sense <= 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_state <= ST_UP;
            r_sense <= 1'b1;
          end
          ST_UP: begin
            if (w_out) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
              r_sense <= ~w_above;
            end else if (w_at_top) begin
              r_state <= ST_DOWN;
              r_sense <= 1'b0;
              r_turn  <= 1'b1;
            end
          end
          ST_DOWN: begin
            if (w_out) begin
              r_state <= ST_FAULT;
              r_fault <= 1'b1;
              r_sense <= ~w_above;
            end else if (w_at_bot) begin
              r_state <= ST_UP;
              r_sense <= 1'b1;
              r_turn  <= 1'b1;
            end
          end
          ST_FAULT: begin
            r_fault <= 1'b1;
            if (w_above) begin
              r_sense <= 1'b0;
            end else if (w_below) begin
              r_sense <= 1'b1;
            end else begin
              // Back in the window: resume in whichever direction we steered.
              r_state <= r_sense ? ST_UP : ST_DOWN;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_sense <= 1'b1;
          end
        endcase
      end
    end
  end

`ifdef UP_DN_CTRL_TURN_CNT_EN
  logic [CNT_W-1:0] r_turn_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_turn_cnt <= '0;
    end else if (w_rev) begin
      r_turn_cnt <= r_turn_cnt + CNT_W'(1);
    end
  end

  assign turn_cnt = r_turn_cnt;
`else
  assign turn_cnt = '0;
`endif

  assign sense = r_sense;
  assign turn  = r_turn;
  assign fault = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_up_dn_sense_ctrl.sv
//------------------------------------------------------------------------------
// tb_up_dn_sense_ctrl: directed bench with a behavioural up/down counter in loop.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_up_dn_sense_ctrl;

`ifdef UP_DN_CTRL_TURN_CNT_EN
  localparam bit TC_EN = 1'b1;
`else
  localparam bit TC_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [31:0] lo_limit = 32'd3;
  logic [31:0] hi_limit = 32'd8;
  logic [31:0] cnt_in;
  logic        sense, turn, fault, cfg_err;
  logic [15:0] turn_cnt;
  logic        sense2, turn2, fault2, cfg_err2;
  logic [1:0]  turn_cnt2;

  logic [31:0] r_cnt;
  logic [31:0] cnt_init = 32'd3;
  logic        cnt_hold = 1'b1;
  logic        ovr = 1'b0;
  logic [31:0] ovr_val = 32'd0;

  int total = 0;
  int bad = 0;

  int e_cnt  [0:24] = '{4,5,6,7,8,7,6,5,4,3,4,5,6,7,8,7,6,5,4,3,4,5,6,7,8};
  int e_sns  [0:24] = '{1,1,1,1,0,0,0,0,0,1,1,1,1,1,0,0,0,0,0,1,1,1,1,1,0};
  int e_trn  [0:24] = '{0,0,0,0,1,0,0,0,0,1,0,0,0,0,1,0,0,0,0,1,0,0,0,0,1};
  int e_tc   [0:24] = '{0,0,0,0,1,1,1,1,1,2,2,2,2,2,3,3,3,3,3,4,4,4,4,4,5};

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) r_cnt <= cnt_init;
    else if (!cnt_hold) r_cnt <= sense ? r_cnt + 32'd1 : r_cnt - 32'd1;
  end

  assign cnt_in = ovr ? ovr_val : r_cnt;

  up_dn_sense_ctrl #(.WIDTH(32), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .lo_limit(lo_limit), .hi_limit(hi_limit),
    .cnt_in(cnt_in), .sense(sense), .turn(turn), .fault(fault), .cfg_err(cfg_err),
    .turn_cnt(turn_cnt)
  );

  up_dn_sense_ctrl #(.WIDTH(32), .CNT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .enable(enable), .lo_limit(lo_limit), .hi_limit(hi_limit),
    .cnt_in(cnt_in), .sense(sense2), .turn(turn2), .fault(fault2), .cfg_err(cfg_err2),
    .turn_cnt(turn_cnt2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] etc(input int n);
    return TC_EN ? 16'(n) : 16'd0;
  endfunction

  // Reset edge with the counter preloaded; leaves the DUT just out of reset.
  task automatic start(input logic [31:0] init, input logic hold, input logic use_ovr,
                       input logic [31:0] oval);
    reset = 1'b1; cnt_init = init; cnt_hold = hold; ovr = use_ovr; ovr_val = oval;
    lo_limit = 32'd3; hi_limit = 32'd8; enable = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; cnt_hold = 1'b1; ovr = 1'b0; cnt_init = 32'd3;
    step(); step();
    total++; if (sense !== 1'b1) begin bad++; $display("FAIL reset_sense got=%b exp=1", sense); end
    total++; if (turn !== 1'b0) begin bad++; $display("FAIL reset_turn got=%b exp=0", turn); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fault); end
    total++; if (turn_cnt !== 16'd0) begin bad++; $display("FAIL reset_turn_cnt got=%0d exp=0", turn_cnt); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
  endtask

  task automatic test_sweep();
    logic [1:0] e2;
    start(32'd3, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 25; i++) begin
      step();
      e2 = TC_EN ? 2'(e_tc[i]) : 2'd0;
      total++; if (cnt_in !== 32'(e_cnt[i])) begin bad++; $display("FAIL sweep_cnt[%0d] got=%0d exp=%0d", i, cnt_in, e_cnt[i]); end
      total++; if (sense !== 1'(e_sns[i])) begin bad++; $display("FAIL sweep_sense[%0d] got=%b exp=%0d", i, sense, e_sns[i]); end
      total++; if (turn !== 1'(e_trn[i])) begin bad++; $display("FAIL sweep_turn[%0d] got=%b exp=%0d", i, turn, e_trn[i]); end
      total++; if (turn_cnt !== etc(e_tc[i])) begin bad++; $display("FAIL sweep_turn_cnt[%0d] got=%0d exp=%0d", i, turn_cnt, etc(e_tc[i])); end
      total++; if (turn_cnt2 !== e2) begin bad++; $display("FAIL sweep_turn_cnt_w2[%0d] got=%0d exp=%0d", i, turn_cnt2, e2); end
      total++; if (fault !== 1'b0) begin bad++; $display("FAIL sweep_fault[%0d] got=%b exp=0", i, fault); end
    end
  endtask

  task automatic test_cfg_err();
    start(32'd4, 1'b1, 1'b1, 32'd4);
    hi_limit = 32'd4;
    #1;
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_hi4 got=%b exp=1", cfg_err); end
    step(); step();
    total++; if (sense !== 1'b1 || turn !== 1'b0) begin bad++; $display("FAIL cfg_err_idle got=%b%b exp=10", sense, turn); end
    hi_limit = 32'd5;
    #1;
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL cfg_err_hi5 got=%b exp=0", cfg_err); end
    step();
    total++; if (sense !== 1'b1 || turn !== 1'b0) begin bad++; $display("FAIL cfg_err_start got=%b%b exp=10", sense, turn); end
    step();
    total++; if (turn !== 1'b1 || sense !== 1'b0) begin bad++; $display("FAIL cfg_err_first_turn got=%b%b exp=10", turn, sense); end
    total++; if (turn_cnt !== etc(1)) begin bad++; $display("FAIL cfg_err_turn_cnt got=%0d exp=%0d", turn_cnt, etc(1)); end
    lo_limit = 32'hFFFF_FFFF; hi_limit = 32'hFFFF_FFFF;
    #1;
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL cfg_err_nowrap got=%b exp=1", cfg_err); end
    step();
    total++; if (sense !== 1'b1 || turn !== 1'b0) begin bad++; $display("FAIL cfg_err_to_idle got=%b%b exp=10", sense, turn); end
  endtask

  task automatic test_fault();
    start(32'd5, 1'b1, 1'b1, 32'd5);
    step(); step();
    ovr_val = 32'd20; step();
    total++; if (fault !== 1'b1 || sense !== 1'b0 || turn !== 1'b0) begin bad++; $display("FAIL fault_above got=%b%b%b exp=100", fault, sense, turn); end
    step();
    total++; if (fault !== 1'b1 || sense !== 1'b0) begin bad++; $display("FAIL fault_hold got=%b%b exp=10", fault, sense); end
    ovr_val = 32'd8; step();
    total++; if (sense !== 1'b0 || turn !== 1'b0) begin bad++; $display("FAIL fault_exit got=%b%b exp=00", sense, turn); end
    ovr_val = 32'd4; step();
    total++; if (turn !== 1'b1 || sense !== 1'b1 || fault !== 1'b1) begin bad++; $display("FAIL fault_down_turn got=%b%b%b exp=111", turn, sense, fault); end
    total++; if (turn_cnt !== etc(1)) begin bad++; $display("FAIL fault_turn_cnt got=%0d exp=%0d", turn_cnt, etc(1)); end
    ovr_val = 32'd2; step();
    total++; if (sense !== 1'b1 || turn !== 1'b0) begin bad++; $display("FAIL fault_below got=%b%b exp=10", sense, turn); end
    ovr_val = 32'd3; step();
    ovr_val = 32'd7; step();
    total++; if (turn !== 1'b1 || sense !== 1'b0) begin bad++; $display("FAIL fault_resume_up got=%b%b exp=10", turn, sense); end
    enable = 1'b0; step();
    total++; if (fault !== 1'b1 || sense !== 1'b1) begin bad++; $display("FAIL fault_sticky got=%b%b exp=11", fault, sense); end
    reset = 1'b1; step(); reset = 1'b0;
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL fault_reset got=%b exp=0", fault); end
  endtask

  task automatic test_enable_drop();
    start(32'd3, 1'b0, 1'b0, 32'd0);
    repeat (7) step();
    total++; if (cnt_in !== 32'd6 || sense !== 1'b0) begin bad++; $display("FAIL en_pre got=%0d/%b exp=6/0", cnt_in, sense); end
    enable = 1'b0; step();
    total++; if (sense !== 1'b1 || turn !== 1'b0 || turn_cnt !== etc(1)) begin bad++; $display("FAIL en_drop got=%b%b/%0d exp=10/%0d", sense, turn, turn_cnt, etc(1)); end
    enable = 1'b1; step();
    total++; if (sense !== 1'b1 || cnt_in !== 32'd6) begin bad++; $display("FAIL en_resume got=%b/%0d exp=1/6", sense, cnt_in); end
    step(); step();
    total++; if (turn !== 1'b1 || sense !== 1'b0 || turn_cnt !== etc(2)) begin bad++; $display("FAIL en_turn got=%b%b/%0d exp=10/%0d", turn, sense, turn_cnt, etc(2)); end
  endtask

  task automatic test_reset_mid();
    start(32'd3, 1'b0, 1'b0, 32'd0);
    repeat (8) step();
    total++; if (cnt_in !== 32'd5 || sense !== 1'b0) begin bad++; $display("FAIL rst_mid_pre got=%0d/%b exp=5/0", cnt_in, sense); end
    reset = 1'b1; step();
    total++; if (sense !== 1'b1 || turn !== 1'b0 || fault !== 1'b0 || turn_cnt !== 16'd0) begin bad++; $display("FAIL rst_mid got=%b%b%b/%0d exp=100/0", sense, turn, fault, turn_cnt); end
    total++; if (cnt_in !== 32'd3) begin bad++; $display("FAIL rst_mid_cnt got=%0d exp=3", cnt_in); end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_cfg_err();
    test_fault();
    test_enable_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
